// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the MIPS core. Tracks the fetch address and
//   applies branch-delay-slot semantics to branch, jump and register-jump
//   redirects. It also reports the link address and the run/halt status.
//
// Ports
//   clk              in   1   core clock, rising edge
//   reset_n          in   1   asynchronous reset, active-low
//   advance          in   1   current instruction retires; 0 holds all state
//   branch_taken     in   1   conditional branch resolved taken
//   branch_offset    in   32  sign-extended, word-shifted byte offset
//   jump             in   1   J/JAL in the current instruction
//   jump_index       in   26  instr_index field of J/JAL
//   jump_reg         in   1   JR/JALR in the current instruction
//   jump_reg_target  in   32  rs value for JR/JALR
//   pc               out  32  address of the current instruction
//   pc_link          out  32  pc+8, link value
//   in_delay_slot    out  1   current instruction sits in a delay slot
//   active           out  1   1 while executing, 0 once halted
//   addr_error       out  1   sticky misaligned JR/JALR target flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic        in_delay_slot,
  output logic        active,
  output logic        addr_error
);

  // 2'b11 is never entered in normal operation; it is treated as a fault.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DELAY  = 2'b01,
    ST_HALTED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pending_r;
  logic        active_r;
  logic        addr_error_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        redirect_s;
  logic        misaligned_s;

  // J/JAL target: keep the 256 MB region of the delay-slot instruction.
  function automatic logic [31:0] jump_target(input logic [31:0] base,
                                              input logic [25:0] index);
    jump_target = {base[31:28], index, 2'b00};
  endfunction

  // Redirect selection with priority jump_reg > jump > branch_taken.
  always_comb begin
    pc_plus4_s   = pc_r + 32'd4;
    target_s     = 32'd0;
    redirect_s   = 1'b0;
    misaligned_s = 1'b0;
    if (jump_reg) begin
      target_s     = jump_reg_target;
      redirect_s   = 1'b1;
      misaligned_s = (jump_reg_target[1:0] != 2'b00);
    end else if (jump) begin
      target_s   = jump_target(pc_plus4_s, jump_index);
      redirect_s = 1'b1;
    end else if (branch_taken) begin
      target_s   = pc_plus4_s + branch_offset;
      redirect_s = 1'b1;
    end else begin
      target_s   = 32'd0;
      redirect_s = 1'b0;
    end
  end

  // Sequencer FSM: PC, pending delay-slot target and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_RUN;
      pc_r         <= RESET_VECTOR;
      pending_r    <= 32'd0;
      active_r     <= 1'b1;
      addr_error_r <= 1'b0;
    end else if (advance) begin
      case (state_r)
        ST_RUN: begin
          if (jump_reg && misaligned_s) begin
            // Bad JR target: stop here, the PC stays on the faulting JR.
            addr_error_r <= 1'b1;
            active_r     <= 1'b0;
            state_r      <= ST_HALTED;
          end else if (redirect_s) begin
            pending_r <= target_s;
            pc_r      <= pc_plus4_s;
            state_r   <= ST_DELAY;
          end else begin
            pc_r <= pc_plus4_s;
          end
        end
        ST_DELAY: begin
          // Redirect inputs are ignored while the delay slot retires.
          pc_r <= pending_r;
          if (pending_r == HALT_ADDR) begin
            active_r <= 1'b0;
            state_r  <= ST_HALTED;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED: begin
          active_r <= 1'b0;
        end
        default: begin
          active_r <= 1'b0;
          state_r  <= ST_HALTED;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign pc            = pc_r;
  assign pc_link       = pc_r + 32'd8;
  assign in_delay_slot = (state_r == ST_DELAY);
  assign active        = active_r;
  assign addr_error    = addr_error_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer. The stimulus process pushes the expected
//   architectural state after each step into a queue. A monitor on the falling
//   clock edge pops each entry and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        reset_n;
  logic        advance;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic [31:0] pc;
  logic [31:0] pc_link;
  logic        in_delay_slot;
  logic        active;
  logic        addr_error;

  typedef struct packed {
    logic [31:0] pc;
    logic        ds;
    logic        act;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  pc_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .advance         (advance),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_index      (jump_index),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .pc              (pc),
    .pc_link         (pc_link),
    .in_delay_slot   (in_delay_slot),
    .active          (active),
    .addr_error      (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      logic [31:0] link_exp;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      link_exp = e.pc + 32'd8;
      checks++;
      if (pc !== e.pc || pc_link !== link_exp || in_delay_slot !== e.ds ||
          active !== e.act || addr_error !== e.err) begin
        errors++;
        $display("FAIL %s: got pc=%h link=%h ds=%b act=%b err=%b, expected pc=%h link=%h ds=%b act=%b err=%b",
                 n, pc, pc_link, in_delay_slot, active, addr_error,
                 e.pc, link_exp, e.ds, e.act, e.err);
      end
    end
  end

  task automatic expect_state(input string n, input logic [31:0] p,
                              input logic ds, input logic act, input logic err);
    exp_t e;
    e.pc  = p;
    e.ds  = ds;
    e.act = act;
    e.err = err;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic idle_inputs();
    advance         = 1'b0;
    branch_taken    = 1'b0;
    branch_offset   = 32'd0;
    jump            = 1'b0;
    jump_index      = 26'd0;
    jump_reg        = 1'b0;
    jump_reg_target = 32'd0;
  endtask

  // One clock of stimulus followed by the expected post-edge state.
  task automatic step(input string n, input logic adv, input logic br,
                      input logic [31:0] off, input logic j, input logic [25:0] idx,
                      input logic jr, input logic [31:0] jrt,
                      input logic [31:0] p, input logic ds, input logic act,
                      input logic err);
    advance         = adv;
    branch_taken    = br;
    branch_offset   = off;
    jump            = j;
    jump_index      = idx;
    jump_reg        = jr;
    jump_reg_target = jrt;
    @(posedge clk);
    #1;
    expect_state(n, p, ds, act, err);
    @(negedge clk);
    #1;
  endtask

  task automatic adv_plain(input string n, input logic [31:0] p,
                           input logic ds, input logic act, input logic err);
    step(n, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, p, ds, act, err);
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    expect_state("reset", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    idle_inputs();

    // 1: reset and sequential fetch
    do_reset();
    adv_plain("seq1", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0);
    adv_plain("seq2", 32'hBFC0_0008, 1'b0, 1'b1, 1'b0);
    adv_plain("seq3", 32'hBFC0_000C, 1'b0, 1'b1, 1'b0);
    adv_plain("seq4", 32'hBFC0_0010, 1'b0, 1'b1, 1'b0);

    // 2: backward branch
    step("br_slot", 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 26'd0, 1'b0, 32'd0,
         32'hBFC0_0014, 1'b1, 1'b1, 1'b0);
    adv_plain("br_tgt", 32'hBFC0_0004, 1'b0, 1'b1, 1'b0);

    // 5b: branch in the delay slot is ignored
    step("br2_slot", 1'b1, 1'b1, 32'h0000_0100, 1'b0, 26'd0, 1'b0, 32'd0,
         32'hBFC0_0008, 1'b1, 1'b1, 1'b0);
    step("ds_branch_ignored", 1'b1, 1'b1, 32'h0000_0040, 1'b0, 26'd0, 1'b0, 32'd0,
         32'hBFC0_0108, 1'b0, 1'b1, 1'b0);
    adv_plain("no_stale_pending", 32'hBFC0_010C, 1'b0, 1'b1, 1'b0);

    // 4: stall inside the delay slot
    step("br3_slot", 1'b1, 1'b1, 32'h0000_0008, 1'b0, 26'd0, 1'b0, 32'd0,
         32'hBFC0_0110, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1'b0, 1'b1, 32'h0000_0400, 1'b1, 26'h155, 1'b1, 32'h0000_0000,
           32'hBFC0_0110, 1'b1, 1'b1, 1'b0);
    end
    adv_plain("stall_release", 32'hBFC0_0118, 1'b0, 1'b1, 1'b0);

    // 5a: priority, jump_reg wins over jump and branch
    step("prio_slot", 1'b1, 1'b1, 32'h0000_0040, 1'b1, 26'h000_0010, 1'b1, 32'h1234_5678,
         32'hBFC0_011C, 1'b1, 1'b1, 1'b0);
    adv_plain("prio_jr_wins", 32'h1234_5678, 1'b0, 1'b1, 1'b0);

    // 6c: wrap from FFFFFFFC to 0 without a halt
    step("wrap_jr_slot", 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hFFFF_FFFC,
         32'h1234_567C, 1'b1, 1'b1, 1'b0);
    adv_plain("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    adv_plain("wrap_zero", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    adv_plain("wrap_after", 32'h0000_0004, 1'b0, 1'b1, 1'b0);

    // 6b: asynchronous reset while in the delay slot
    step("pre_reset_slot", 1'b1, 1'b1, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0,
         32'h0000_0008, 1'b1, 1'b1, 1'b0);
    advance = 1'b1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    expect_state("async_reset", 32'hBFC0_0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    idle_inputs();
    reset_n = 1'b1;

    // 3b: J with all-ones index
    step("j_slot", 1'b1, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'd0,
         32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
    adv_plain("j_target", 32'hBFFF_FFFC, 1'b0, 1'b1, 1'b0);

    // 6a: misaligned JR target
    step("jr_misaligned", 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'hBFC0_0002,
         32'hBFFF_FFFC, 1'b0, 1'b0, 1'b1);
    adv_plain("err_sticky", 32'hBFFF_FFFC, 1'b0, 1'b0, 1'b1);

    // 3a: JR to the halt address
    do_reset();
    step("halt_slot", 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, 32'h0000_0000,
         32'hBFC0_0004, 1'b1, 1'b1, 1'b0);
    adv_plain("halt_reached", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    step("halt_hold", 1'b1, 1'b1, 32'h0000_0100, 1'b1, 26'h123, 1'b1, 32'h0000_0040,
         32'h0000_0000, 1'b0, 1'b0, 1'b0);
    adv_plain("halt_hold2", 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
